// File: rtl/i2s_rx_capture.sv
`timescale 1ns/1ps
// i2s_rx_capture
//   Capture end of the codec I2S record link. The bit clock, word select and
//   data lines are oversampled in the mclk domain, deserialized into left and
//   right words, and each completed stereo frame is offered as one pair.
//
// Ports
//   mclk               codec master clock (>= 4x bclk), the only clock
//   rstn               asynchronous active-low reset
//   audio_I2S_bclk     bit clock, sampled only
//   audio_I2S_reclrc   word select, 0 = left, 1 = right
//   audio_I2S_recdat   serial data, MSB first, one bclk after the reclrc edge
//   left_sample        last completed left word (two's complement)
//   right_sample       last completed right word (two's complement)
//   sample_valid       a frame pair is available
//   sample_ready       consumer accepts the pair
//   overrun            sticky: a frame completed while the previous one waited
//   frame_error        sticky: a short or long slot was seen
//   err_clear          one-cycle pulse clearing both sticky flags
//   state_dbg          current capture FSM state (IDLE=0, LEFT=1, RIGHT=2)
//
// Handshake: sample_valid rises when a frame is committed and holds until the
// mclk edge where sample_valid && sample_ready, which clears it. A commit on
// that same edge wins (valid stays high with the new pair, no overrun). A
// commit while valid is high and ready is low overwrites the pair and sets
// overrun.
module i2s_rx_capture #(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic                   mclk,
  input  logic                   rstn,
  input  logic                   audio_I2S_bclk,
  input  logic                   audio_I2S_reclrc,
  input  logic                   audio_I2S_recdat,
  output logic [SAMPLE_BITS-1:0] left_sample,
  output logic [SAMPLE_BITS-1:0] right_sample,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun,
  output logic                   frame_error,
  input  logic                   err_clear,
  output logic [1:0]             state_dbg
);

  localparam int KW = $clog2(SLOT_BITS + 2);
  localparam logic [KW-1:0] K_WORD = KW'(SAMPLE_BITS);
  localparam logic [KW-1:0] K_SAT  = KW'(SLOT_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] bclk_sync, lrc_sync, dat_sync;
  logic bclk_s, lrc_s, dat_s;

  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      bclk_sync <= '0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], audio_I2S_bclk};
      lrc_sync  <= {lrc_sync[SYNC_STAGES-2:0],  audio_I2S_reclrc};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0],  audio_I2S_recdat};
    end
  end

  assign bclk_s = bclk_sync[SYNC_STAGES-1];
  assign lrc_s  = lrc_sync[SYNC_STAGES-1];
  assign dat_s  = dat_sync[SYNC_STAGES-1];

  // ------------------------------------------- slot position and shifting
  // Stage 1: on each bclk rise, track the slot position k and shift data.
  // The events seen on that rise are registered for the FSM stage.
  logic                   bclk_d, lrc_prev;
  logic                   rise_q, trans_q;
  logic [KW-1:0]          k, k_old;
  logic [SAMPLE_BITS-1:0] shift;
  logic                   bclk_rise, lrc_change, shift_en;
  logic [KW-1:0]          k_next;

  assign bclk_rise  = bclk_s & ~bclk_d;
  assign lrc_change = lrc_s ^ lrc_prev;

  always_comb begin
    k_next = k;
    if (lrc_change)      k_next = '0;
    else if (k != K_SAT) k_next = k + KW'(1);
  end

  // k = 0 carries the previous slot's LSB; only k = 1..SAMPLE_BITS belong
  // to this slot's word.
  assign shift_en = (k_next != '0) && (k_next <= K_WORD);

  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      bclk_d   <= 1'b0;
      lrc_prev <= 1'b0;
      rise_q   <= 1'b0;
      trans_q  <= 1'b0;
      k        <= '0;
      k_old    <= '0;
      shift    <= '0;
    end else begin
      bclk_d  <= bclk_s;
      rise_q  <= bclk_rise;
      trans_q <= bclk_rise & lrc_change;
      if (bclk_rise) begin
        lrc_prev <= lrc_s;
        k        <= k_next;
        k_old    <= k;
        if (shift_en) shift <= {shift[SAMPLE_BITS-2:0], dat_s};
      end
    end
  end

  // ----------------------------------------------------------------- FSM
  // Stage 2: act on the registered events. lrc_prev already holds the new
  // word-select level here, and k holds the updated position.
  state_t state, state_next;
  logic   word_done, short_slot, long_slot;
  logic   hold_left, commit_set, err_set;
  logic   commit_q;
  logic [SAMPLE_BITS-1:0] left_hold, right_hold;

  assign word_done  = rise_q && !trans_q && (k == K_WORD);
  assign short_slot = trans_q && (k_old < K_WORD);
  assign long_slot  = rise_q && (k == K_SAT);

  always_comb begin
    state_next = state;
    hold_left  = 1'b0;
    commit_set = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        // Only a right-to-left edge starts a frame.
        if (trans_q && !lrc_prev) state_next = LEFT;
      end
      LEFT: begin
        if (trans_q) begin
          if (short_slot) begin
            err_set    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RIGHT;
          end
        end else begin
          if (word_done) hold_left = 1'b1;
          if (long_slot) err_set   = 1'b1;
        end
      end
      RIGHT: begin
        if (trans_q) begin
          if (short_slot) begin
            err_set    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = LEFT;
          end
        end else begin
          if (word_done) commit_set = 1'b1;
          if (long_slot) err_set    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      left_hold  <= '0;
      right_hold <= '0;
      commit_q   <= 1'b0;
    end else begin
      state    <= state_next;
      commit_q <= commit_set;
      if (hold_left)  left_hold  <= shift;
      if (commit_set) right_hold <= shift;
    end
  end

  assign state_dbg = state;

  // -------------------------------------------------------------- output
  // Stage 3: load the pair and run the handshake and sticky flags.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      if (commit_q) begin
        left_sample  <= left_hold;
        right_sample <= right_hold;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      overrun     <= (overrun & ~err_clear) |
                     (commit_q & sample_valid & ~sample_ready);
      frame_error <= (frame_error & ~err_clear) | err_set;
    end
  end

endmodule

// File: tb/tb_i2s_rx_capture.sv
`timescale 1ns/1ps
// Bench for i2s_rx_capture: serializes stereo frames onto the I2S record
// lines (bclk = mclk/4) and checks captured pairs against the frames sent.
module tb_i2s_rx_capture;

  localparam int W  = 16;
  localparam int SS = 2;

  // ------------------------------------------------------ clock / reset
  logic mclk = 1'b0;
  logic rstn, bclk, lrc, dat, sample_ready, err_clear;
  logic [W-1:0] left_sample, right_sample;
  logic sample_valid, overrun, frame_error;
  logic [1:0] state_dbg;

  always #5 mclk = ~mclk;

  int pc = 0;  // posedges seen so far
  always @(posedge mclk) pc <= pc + 1;

  i2s_rx_capture #(.SAMPLE_BITS(W), .SLOT_BITS(32), .SYNC_STAGES(SS)) dut (
    .mclk            (mclk),
    .rstn            (rstn),
    .audio_I2S_bclk  (bclk),
    .audio_I2S_reclrc(lrc),
    .audio_I2S_recdat(dat),
    .left_sample     (left_sample),
    .right_sample    (right_sample),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .overrun         (overrun),
    .frame_error     (frame_error),
    .err_clear       (err_clear),
    .state_dbg       (state_dbg)
  );

  // ---------------------------------------------------------- scoreboard
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] got_q[$];
  int total = 0;
  int bad   = 0;

  // Monitor: records every accepted pair, the posedge count at which valid
  // was last seen rising, and the longest run of valid-high cycles.
  int   valid_rise_pc = -1;
  int   run = 0;
  int   max_run = 0;
  logic valid_prev = 1'b0;
  always @(negedge mclk) begin
    #2;
    if (sample_valid && sample_ready) got_q.push_back({left_sample, right_sample});
    if (sample_valid && !valid_prev) valid_rise_pc = pc;
    run = sample_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
    valid_prev = sample_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_frames(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_frame"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  // ------------------------------------------------------------- drivers
  int last_rise_pc  = 0;
  int right_final_pc = -1;

  // One bclk period: low for 2 mclk (data/lrc change), high for 2 mclk.
  task automatic bit_out(input logic l, input logic d);
    @(negedge mclk); bclk = 1'b0; lrc = l; dat = d;
    @(negedge mclk);
    @(negedge mclk); bclk = 1'b1; last_rise_pc = pc;
    @(negedge mclk);
  endtask

  // Slot bit 0 is the previous word's LSB position, bits 1..W carry the word
  // MSB first, anything after is padding (all 1s, or random if rnd_pad).
  task automatic send_slot(input logic l, input logic [W-1:0] word,
                           input int nbits, input bit rnd_pad);
    for (int i = 0; i < nbits; i++) begin
      logic b;
      if (i >= 1 && i <= W) b = word[W-i];
      else                  b = rnd_pad ? 1'($urandom_range(0, 1)) : 1'b1;
      bit_out(l, b);
      if (l && i == W) right_final_pc = last_rise_pc;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l_word, input logic [W-1:0] r_word,
                            input bit rnd_pad);
    send_slot(1'b0, l_word, 32, rnd_pad);
    send_slot(1'b1, r_word, 32, rnd_pad);
  endtask

  task automatic pulse_err_clear();
    @(negedge mclk); err_clear = 1'b1;
    @(negedge mclk); err_clear = 1'b0;
    @(negedge mclk);
  endtask

  // ------------------------------------------------------------ sequence
  initial begin
    logic [W-1:0] a, b;
    rstn = 1'b0; bclk = 1'b0; lrc = 1'b1; dat = 1'b0;
    sample_ready = 1'b0; err_clear = 1'b0;
    repeat (4) @(negedge mclk);

    // Reset state
    check("rst_left",  32'(left_sample),  32'h0);
    check("rst_right", 32'(right_sample), 32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_ovr",   32'(overrun),      32'h0);
    check("rst_ferr",  32'(frame_error),  32'h0);
    check("rst_state", 32'(state_dbg),    32'h0);
    rstn = 1'b1;

    // Normal frame with latency and one-cycle valid
    sample_ready = 1'b1;
    send_slot(1'b1, 16'h0000, 4, 1'b0);
    max_run = 0;
    send_frame(16'h1234, 16'hABCD, 1'b0);
    exp_q.push_back({16'h1234, 16'hABCD});
    check("latency", 32'(valid_rise_pc - right_final_pc), 32'(SS + 3));
    check("valid_one_cycle", 32'(max_run), 32'd1);
    compare_frames("normal");

    // Extremes
    send_frame(16'h8000, 16'h7FFF, 1'b0); exp_q.push_back({16'h8000, 16'h7FFF});
    send_frame(16'hFFFF, 16'h0001, 1'b0); exp_q.push_back({16'hFFFF, 16'h0001});
    compare_frames("extremes");

    // Random words with random padding
    for (int n = 0; n < 6; n++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      send_frame(a, b, 1'b1);
      exp_q.push_back({a, b});
    end
    compare_frames("random");
    check("random_ovr",  32'(overrun),     32'h0);
    check("random_ferr", 32'(frame_error), 32'h0);

    // Backpressure across two frames
    @(negedge mclk); sample_ready = 1'b0;
    send_frame(16'h1111, 16'h2222, 1'b0);
    send_frame(16'h3333, 16'h4444, 1'b0);
    check("bp_valid", 32'(sample_valid), 32'h1);
    check("bp_left",  32'(left_sample),  32'h3333);
    check("bp_right", 32'(right_sample), 32'h4444);
    check("bp_ovr",   32'(overrun),      32'h1);
    pulse_err_clear();
    check("bp_ovr_clr", 32'(overrun), 32'h0);
    @(negedge mclk); sample_ready = 1'b1;
    @(negedge mclk);
    check("bp_drained", 32'(sample_valid), 32'h0);
    exp_q.push_back({16'h3333, 16'h4444});
    compare_frames("backpressure");

    // Accept on the exact commit cycle
    @(negedge mclk); sample_ready = 1'b0;
    send_frame(16'h7777, 16'h8888, 1'b0);
    right_final_pc = -1;
    fork
      send_frame(16'h9999, 16'hAAAA, 1'b0);
      begin
        wait (right_final_pc >= 0);
        while (pc < right_final_pc + 4) @(negedge mclk);
        sample_ready = 1'b1;
        @(negedge mclk);
        sample_ready = 1'b0;
      end
    join
    check("sim_valid", 32'(sample_valid), 32'h1);
    check("sim_left",  32'(left_sample),  32'h9999);
    check("sim_right", 32'(right_sample), 32'hAAAA);
    check("sim_ovr",   32'(overrun),      32'h0);
    exp_q.push_back({16'h7777, 16'h8888});
    @(negedge mclk); sample_ready = 1'b1;
    @(negedge mclk);
    exp_q.push_back({16'h9999, 16'hAAAA});
    check("sim_drained", 32'(sample_valid), 32'h0);
    compare_frames("simultaneous");

    // Short left slot, then a clean frame
    send_slot(1'b0, 16'hC3C3, 10, 1'b0);
    send_slot(1'b1, 16'h5A5A, 32, 1'b0);
    check("short_ferr",  32'(frame_error), 32'h1);
    check("short_state", 32'(state_dbg),   32'h0);
    compare_frames("short_none");
    send_frame(16'h5555, 16'h6666, 1'b0);
    exp_q.push_back({16'h5555, 16'h6666});
    compare_frames("short_recover");
    pulse_err_clear();
    check("short_ferr_clr", 32'(frame_error), 32'h0);

    // Long left slot: flagged, data still captured
    send_slot(1'b0, 16'h0F0F, 36, 1'b0);
    send_slot(1'b1, 16'hF0F0, 32, 1'b0);
    exp_q.push_back({16'h0F0F, 16'hF0F0});
    check("long_ferr", 32'(frame_error), 32'h1);
    compare_frames("long");
    pulse_err_clear();

    // Reset mid-left-word, release mid-right-slot
    @(negedge mclk); sample_ready = 1'b0;
    send_frame(16'h1357, 16'h2468, 1'b0);
    check("pre_rst_valid", 32'(sample_valid), 32'h1);
    send_slot(1'b0, 16'hFFFF, 8, 1'b0);
    @(negedge mclk); rstn = 1'b0;
    #1;
    check("mid_rst_left",  32'(left_sample),  32'h0);
    check("mid_rst_right", 32'(right_sample), 32'h0);
    check("mid_rst_valid", 32'(sample_valid), 32'h0);
    check("mid_rst_state", 32'(state_dbg),    32'h0);
    for (int i = 0; i < 5; i++) bit_out(1'b1, 1'($urandom_range(0, 1)));
    rstn = 1'b1;
    sample_ready = 1'b1;
    send_slot(1'b1, 16'hBEEF, 12, 1'b1);
    check("midstart_valid", 32'(sample_valid), 32'h0);
    check("midstart_state", 32'(state_dbg),    32'h0);
    compare_frames("midstart_none");
    a = 16'($urandom_range(0, 65535));
    b = 16'($urandom_range(0, 65535));
    send_frame(a, b, 1'b1);
    exp_q.push_back({a, b});
    compare_frames("midstart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx_capture.md
Name: i2s_rx_capture

Overview:
- I2S receive path: the capture end of the codec serial link, the counterpart to the master playback serializer that drives audio_I2S_pbdat.
- Oversamples the codec record lines (bclk, reclrc, recdat) in the mclk domain and deserializes left/right words.
- Presents each completed stereo frame as one shortint pair on a valid/ready handshake to the source-mixing logic, e.g. a future line-in source or a BRAM record path.

Parameters:
- SAMPLE_BITS, 16, captured bits per channel (MSB first); output width.
- SLOT_BITS, 32, nominal bclk periods per half-frame; used only for the long-slot check.
- SYNC_STAGES, 2, flip-flop synchronizer depth on bclk, reclrc and recdat.

Ports:
- mclk  in  1  single clock; codec master clock, frequency at least 4x bclk.
- rstn  in  1  reset, asynchronous assert, active-low.
- audio_I2S_bclk  in  1  bit clock, asynchronous to mclk and sampled only.
- audio_I2S_reclrc  in  1  record word select; 0 = left, 1 = right.
- audio_I2S_recdat  in  1  record serial data.
- left_sample  out  SAMPLE_BITS  last completed left word (signed).
- right_sample  out  SAMPLE_BITS  last completed right word (signed).
- sample_valid  out  1  frame pair available.
- sample_ready  in  1  consumer accepts the pair when sample_valid && sample_ready.
- overrun  out  1  sticky: a new frame completed while sample_valid was still high.
- frame_error  out  1  sticky: a short or long slot was seen.
- err_clear  in  1  one-cycle pulse; clears overrun and frame_error.

Behaviour:
- Reset: rstn low asynchronously forces the following, regardless of bit position.
  - left_sample = 0, right_sample = 0, sample_valid = 0, overrun = 0, frame_error = 0.
  - Synchronizers cleared to 0, bit counter 0, shift register 0, FSM in IDLE.
  - The partial word is discarded; no frame is emitted until a full left+right pair is captured after reset.
- Sync/edge detect:
  - SYNC_STAGES-deep synchronizers on all three inputs, plus one delayed copy of bclk.
  - bclk_rise = synced bclk 1 and delayed copy 0; all capture happens only on mclk cycles where bclk_rise = 1.
- Slot position k: on bclk_rise, if synced reclrc differs from lrc_prev then k <= 0, else k <= k+1, saturating at SLOT_BITS+1. lrc_prev updates on every bclk_rise.
- Data capture (standard I2S one-bit delay):
  - Bits at k = 1..SAMPLE_BITS are shifted in MSB first.
  - k = 0 (LSB of the previous slot) is ignored, as are bits with k > SAMPLE_BITS.
  - Word complete at the bclk_rise where k becomes SAMPLE_BITS.
- FSM states IDLE, LEFT, RIGHT:
  - IDLE: ignores data. Goes to LEFT on a bclk_rise with reclrc transition 1->0. A 0->1 transition stays in IDLE.
  - LEFT: on word complete, hold the word in left_hold. On reclrc transition 0->1, go to RIGHT.
  - RIGHT: on word complete, commit the frame: left_sample <= left_hold, right_sample <= the new word, sample_valid <= 1, on the next mclk edge. On reclrc transition 1->0, go to LEFT.
- Slot errors:
  - Short slot: reclrc transitions before the current slot reached word complete. Set frame_error, discard that channel's word, go to IDLE; the next 1->0 transition resynchronizes.
  - Long slot: k exceeds SLOT_BITS. Set frame_error, stay in state; data is still accepted.
- Handshake:
  - sample_valid stays high until the mclk edge where sample_valid && sample_ready; it clears on that edge.
  - Output samples are stable while sample_valid = 1 unless an overrun occurs.
  - If a commit and an accept fall on the same cycle, the commit wins: sample_valid stays 1, the new data loads, and overrun is not set.
  - If a commit occurs while sample_valid = 1 and sample_ready = 0, the new data overwrites the outputs, sample_valid stays 1 and overrun is set.
- err_clear: clears both sticky flags. If a new error occurs on the same cycle, the flag stays set (set wins).
- Latency: sample_valid rises SYNC_STAGES+2 mclk cycles after the first mclk edge that samples bclk high for the right word's final bit.
- Width rules: no arithmetic on samples; words are passed through bit-exact as two's complement.

Test Plan:
- Normal frame: 64-bclk frames at mclk = 4x bclk, left 0x1234, right 0xABCD -> sample_valid after SYNC_STAGES+2 cycles, left_sample = 0x1234, right_sample = 0xABCD; sample_ready held 1 -> sample_valid stays high 1 cycle per frame.
- Extremes: left 0x8000, right 0x7FFF, then 0xFFFF/0x0001 -> exact bit-for-bit output, MSB alignment correct, trailing padding bits (all 1s) ignored.
- Backpressure: sample_ready = 0 across two frames (0x1111/0x2222 then 0x3333/0x4444) -> overrun = 1, outputs 0x3333/0x4444; err_clear pulse -> overrun = 0.
- Short slot: reclrc toggles after 10 bits of the left slot -> frame_error = 1, no sample_valid for that frame; the next clean frame 0x5555/0x6666 is captured correctly.
- Mid-start and reset: release rstn while reclrc = 1 mid-right-slot -> no output until a full left+right pair; assert rstn low mid-left-word -> all outputs 0 immediately, FSM in IDLE.
- Simultaneous accept and commit: sample_ready pulses on the exact commit cycle -> sample_valid remains 1, new data present, overrun = 0.
